// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; in_range is also used by the data memory bounds check.
package fetch_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 24;
  localparam int PC_STEP = 4;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} fetch_state_t;

  // Word index must fit below 'words' and nothing may be set above bit 21.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned words);
    return (addr[ADDR_W-1:22] == '0) && (32'(addr[21:2]) < words);
  endfunction

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter with synchronous reset, load (redirect) and increment controls.
module pc_register #(
  parameter int              ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  import fetch_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  // Load wins over increment; increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, branch redirect with bubble, and sticky fault.
module fetch_unit #(
  parameter int                ADDR_W    = 24,
  parameter int                INSTR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC  = 24'h000000,
  parameter int                MEM_WORDS = 140
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rd,
  input  logic                       stall,
  input  logic                       branch_valid,
  input  logic [ADDR_W-1:0]          branch_target,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  output logic                       fault,
  output fetch_pkg::fetch_state_t    state
);
  import fetch_pkg::*;

  // Handshake: instr/instr_pc are meaningful only while instr_valid=1; decode raises
  // stall to hold them, and a branch always produces one instr_valid=0 bubble.

  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;
  logic              ir_capture;
  logic              valid_next;
  logic              target_legal;
  logic              pc_legal;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .load_value (branch_target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  assign imem_addr    = pc;
  assign fault        = (state == FAULT);
  assign target_legal = (branch_target[1:0] == 2'b00) && in_range(branch_target, MEM_WORDS);
  assign pc_legal     = in_range(pc, MEM_WORDS);

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ir_capture = 1'b0;
    valid_next = instr_valid;
    case (state)
      RUN: begin
        if (branch_valid) begin
          valid_next = 1'b0;
          if (target_legal) begin
            pc_load = 1'b1;
          end else begin
            state_next = FAULT;
          end
        end else if (stall) begin
          valid_next = instr_valid;
        end else if (!pc_legal) begin
          state_next = FAULT;
          valid_next = 1'b0;
        end else begin
          ir_capture = 1'b1;
          pc_inc     = 1'b1;
          valid_next = 1'b1;
        end
      end
      FAULT: begin
        // Only a legal redirect leaves FAULT; stall has no effect here.
        valid_next = 1'b0;
        if (branch_valid && target_legal) begin
          pc_load    = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      instr_valid <= valid_next;
      if (ir_capture) begin
        instr    <= imem_rd;
        instr_pc <= pc;
      end
    end
  end

endmodule
